// File: rtl/modelbuf_read_arbiter.sv
// Model-buffer read arbiter: round-robin sharing of the single model-buffer
// read port between NUM_REQ triangle-fetch requesters. A tag FIFO remembers
// which requester owns each outstanding read so that in-order responses can
// be steered back to their owner.

package modelbuf_read_arbiter_pkg;

  typedef struct packed {
    logic [7:0]  model_index;
    logic [15:0] triangle_index;
  } modelbuf_read_t;

  typedef struct packed {
    logic [31:0] v0;
    logic [31:0] v1;
    logic [31:0] v2;
  } triangle_t;

  typedef struct packed {
    logic last;
  } triangle_meta_t;

endpackage

module modelbuf_read_arbiter
  import modelbuf_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                     clk,
  input  logic                                     rstn,
  input  logic           [NUM_REQ-1:0]             req_valid,
  output logic           [NUM_REQ-1:0]             req_ready,
  input  modelbuf_read_t                           req_data [NUM_REQ],
  output logic                                     buf_req_valid,
  input  logic                                     buf_req_ready,
  output modelbuf_read_t                           buf_req_data,
  input  logic                                     buf_rsp_valid,
  output logic                                     buf_rsp_ready,
  input  triangle_t                                buf_rsp_data,
  input  triangle_meta_t                           buf_rsp_metadata,
  output logic           [NUM_REQ-1:0]             rsp_valid,
  input  logic           [NUM_REQ-1:0]             rsp_ready,
  output triangle_t                                rsp_data,
  output triangle_meta_t                           rsp_metadata,
  output logic           [$clog2(MAX_OUTSTANDING+1)-1:0] inflight,
  output logic                                     err_orphan
);

  localparam int TAG_W = $clog2(NUM_REQ);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_OUTSTANDING);
  localparam logic [TAG_W-1:0] GRANT_RST = TAG_W'(NUM_REQ - 1);

  logic [TAG_W-1:0] last_grant_r;
  logic [TAG_W-1:0] grant_s;
  logic             grant_vld_s;
  logic [TAG_W-1:0] head_s;
  logic             not_empty_s;
  logic             not_full_s;
  logic             push_s;
  logic             pop_s;

  logic [TAG_W-1:0] tag_fifo_r [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             err_orphan_r;

  // Round-robin search starting just after the previous winner.
  always_comb begin
    grant_s     = last_grant_r;
    grant_vld_s = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!grant_vld_s && req_valid[(int'(last_grant_r) + k) % NUM_REQ]) begin
        grant_s     = TAG_W'((int'(last_grant_r) + k) % NUM_REQ);
        grant_vld_s = 1'b1;
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  assign not_empty_s = (count_r != {CNT_W{1'b0}});
  assign not_full_s  = (count_r < CNT_MAX);
  assign head_s      = tag_fifo_r[rd_ptr_r];

  assign buf_req_valid = grant_vld_s && not_full_s;
  assign buf_req_data  = req_data[grant_s];
  assign buf_rsp_ready = not_empty_s && rsp_ready[head_s];

  assign push_s = buf_req_valid && buf_req_ready;
  assign pop_s  = buf_rsp_valid && buf_rsp_ready;

  assign rsp_data     = buf_rsp_data;
  assign rsp_metadata = buf_rsp_metadata;
  assign inflight     = count_r;
  assign err_orphan   = err_orphan_r;

  // Per-requester request accept and one-hot response steering to the head owner.
  always_comb begin
    req_ready = {NUM_REQ{1'b0}};
    rsp_valid = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = (grant_s == TAG_W'(i)) && buf_req_valid && buf_req_ready;
      rsp_valid[i] = buf_rsp_valid && not_empty_s && (head_s == TAG_W'(i));
    end
  end

  // Arbitration history: remember the winner of each accepted request.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant_r <= GRANT_RST;
    end else if (push_s) begin
      last_grant_r <= grant_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  // Tag FIFO storage and write pointer: record owner of each issued read.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        tag_fifo_r[i] <= {TAG_W{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
    end else if (push_s) begin
      tag_fifo_r[wr_ptr_r] <= grant_s;
      wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
    end else begin
      wr_ptr_r <= wr_ptr_r;
    end
  end

  // Tag FIFO read pointer: retire the head when its response is consumed.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr_r <= {PTR_W{1'b0}};
    end else if (pop_s) begin
      rd_ptr_r <= rd_ptr_r + PTR_W'(1);
    end else begin
      rd_ptr_r <= rd_ptr_r;
    end
  end

  // Occupancy count; simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_r <= {CNT_W{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky flag for a response arriving with no outstanding read to own it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_orphan_r <= 1'b0;
    end else if (buf_rsp_valid && !not_empty_s) begin
      err_orphan_r <= 1'b1;
    end else begin
      err_orphan_r <= err_orphan_r;
    end
  end

endmodule

// File: tb/tb_modelbuf_read_arbiter.sv
// Directed self-checking bench for modelbuf_read_arbiter (NUM_REQ=2, MAX_OUTSTANDING=4).
module tb_modelbuf_read_arbiter;
  import modelbuf_read_arbiter_pkg::*;

  logic           clk;
  logic           rstn;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  modelbuf_read_t req_data [2];
  logic           buf_req_valid;
  logic           buf_req_ready;
  modelbuf_read_t buf_req_data;
  logic           buf_rsp_valid;
  logic           buf_rsp_ready;
  triangle_t      buf_rsp_data;
  triangle_meta_t buf_rsp_metadata;
  logic [1:0]     rsp_valid;
  logic [1:0]     rsp_ready;
  triangle_t      rsp_data;
  triangle_meta_t rsp_metadata;
  logic [2:0]     inflight;
  logic           err_orphan;

  int checks = 0;
  int errors = 0;

  modelbuf_read_arbiter #(.NUM_REQ(2), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .buf_req_valid(buf_req_valid), .buf_req_ready(buf_req_ready), .buf_req_data(buf_req_data),
    .buf_rsp_valid(buf_rsp_valid), .buf_rsp_ready(buf_rsp_ready),
    .buf_rsp_data(buf_rsp_data), .buf_rsp_metadata(buf_rsp_metadata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_metadata(rsp_metadata),
    .inflight(inflight), .err_orphan(err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; req_valid = 2'b00; buf_req_ready = 1'b1; buf_rsp_valid = 1'b0;
    rsp_ready = 2'b00; buf_rsp_data = '0; buf_rsp_metadata = '0;
    req_data[0] = '{model_index: 8'h10, triangle_index: 16'h0100};
    req_data[1] = '{model_index: 8'h21, triangle_index: 16'h0201};
    step(); step();
    #1;
    checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL reset_inflight got=%0d exp=0", inflight); end
    checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL reset_err_orphan got=%b exp=0", err_orphan); end
    checks++; if (buf_req_valid !== 1'b0) begin errors++; $display("FAIL reset_buf_req_valid got=%b exp=0", buf_req_valid); end
    checks++; if (buf_rsp_ready !== 1'b0) begin errors++; $display("FAIL reset_buf_rsp_ready got=%b exp=0", buf_rsp_ready); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
    rstn = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [1:0]     exp_rdy;
    logic [1:0]     exp_rv;
    logic [2:0]     exp_inf;
    modelbuf_read_t exp_data;
    for (int c = 0; c < 8; c++) begin
      step();
      req_valid     = (c < 6) ? 2'b11 : 2'b00;
      rsp_ready     = 2'b11;
      buf_rsp_valid = (c >= 2);
      buf_rsp_data  = '{v0: 32'hA000 + c, v1: 32'hB000 + c, v2: 32'hC000 + c};
      buf_rsp_metadata.last = c[0];
      #1;
      exp_inf = (c < 2) ? 3'(c) : ((c < 7) ? 3'd2 : 3'd1);
      checks++; if (inflight !== exp_inf) begin errors++; $display("FAIL rr_inflight c=%0d got=%0d exp=%0d", c, inflight, exp_inf); end
      if (c < 6) begin
        exp_rdy  = c[0] ? 2'b10 : 2'b01;
        exp_data = c[0] ? req_data[1] : req_data[0];
        checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, req_ready, exp_rdy); end
        checks++; if (buf_req_data !== exp_data) begin errors++; $display("FAIL rr_buf_req_data c=%0d got=%h exp=%h", c, buf_req_data, exp_data); end
      end
      if (c >= 2) begin
        exp_rv = c[0] ? 2'b10 : 2'b01;
        checks++; if (rsp_valid !== exp_rv) begin errors++; $display("FAIL rr_rsp_valid c=%0d got=%b exp=%b", c, rsp_valid, exp_rv); end
        checks++; if (buf_rsp_ready !== 1'b1) begin errors++; $display("FAIL rr_buf_rsp_ready c=%0d got=%b exp=1", c, buf_rsp_ready); end
        checks++; if (rsp_data.v1 !== 32'hB000 + c) begin errors++; $display("FAIL rr_rsp_data c=%0d got=%h exp=%h", c, rsp_data.v1, 32'hB000 + c); end
        checks++; if (rsp_metadata.last !== c[0]) begin errors++; $display("FAIL rr_rsp_last c=%0d got=%b exp=%b", c, rsp_metadata.last, c[0]); end
      end
    end
    step();
    buf_rsp_valid = 1'b0;
    #1;
    checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL rr_drained got=%0d exp=0", inflight); end
  endtask

  task automatic test_fill_stall();
    req_valid = 2'b01; buf_rsp_valid = 1'b0; rsp_ready = 2'b01;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL fill_req_ready c=%0d got=%b exp=01", c, req_ready); end
      checks++; if (inflight !== 3'(c)) begin errors++; $display("FAIL fill_inflight c=%0d got=%0d exp=%0d", c, inflight, c); end
      step();
    end
    #1;
    checks++; if (inflight !== 3'd4) begin errors++; $display("FAIL full_inflight got=%0d exp=4", inflight); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL full_req_ready got=%b exp=00", req_ready); end
    checks++; if (buf_req_valid !== 1'b0) begin errors++; $display("FAIL full_buf_req_valid got=%b exp=0", buf_req_valid); end
    step();
    buf_rsp_valid = 1'b1;
    #1;
    checks++; if (buf_rsp_ready !== 1'b1) begin errors++; $display("FAIL fullpop_buf_rsp_ready got=%b exp=1", buf_rsp_ready); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL fullpop_req_ready got=%b exp=00", req_ready); end
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL fullpop_rsp_valid got=%b exp=01", rsp_valid); end
    step();
    buf_rsp_valid = 1'b0;
    #1;
    checks++; if (inflight !== 3'd3) begin errors++; $display("FAIL afterpop_inflight got=%0d exp=3", inflight); end
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL afterpop_req_ready got=%b exp=01", req_ready); end
    step();
    req_valid = 2'b00; buf_rsp_valid = 1'b1;
    #1;
    checks++; if (inflight !== 3'd4) begin errors++; $display("FAIL refill_inflight got=%0d exp=4", inflight); end
    repeat (4) step();
    buf_rsp_valid = 1'b0;
    #1;
    checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL fill_drained got=%0d exp=0", inflight); end
  endtask

  task automatic test_owner_stall();
    logic [2:0] exp_inf;
    logic [1:0] exp_rdy;
    logic [1:0] exp_rv;
    step();
    req_valid = 2'b10; buf_rsp_valid = 1'b0; rsp_ready = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL stall_first_grant got=%b exp=10", req_ready); end
    for (int k = 1; k <= 5; k++) begin
      step();
      req_valid = 2'b01; buf_rsp_valid = 1'b1;
      #1;
      exp_inf = (k < 4) ? 3'(k) : 3'd4;
      exp_rdy = (k < 4) ? 2'b01 : 2'b00;
      checks++; if (buf_rsp_ready !== 1'b0) begin errors++; $display("FAIL stall_buf_rsp_ready k=%0d got=%b exp=0", k, buf_rsp_ready); end
      checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL stall_rsp_valid k=%0d got=%b exp=10", k, rsp_valid); end
      checks++; if (inflight !== exp_inf) begin errors++; $display("FAIL stall_inflight k=%0d got=%0d exp=%0d", k, inflight, exp_inf); end
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL stall_req_ready k=%0d got=%b exp=%b", k, req_ready, exp_rdy); end
    end
    for (int d = 0; d < 4; d++) begin
      step();
      req_valid = 2'b00; rsp_ready = 2'b11; buf_rsp_valid = 1'b1;
      #1;
      exp_rv = (d == 0) ? 2'b10 : 2'b01;
      checks++; if (rsp_valid !== exp_rv) begin errors++; $display("FAIL unstall_rsp_valid d=%0d got=%b exp=%b", d, rsp_valid, exp_rv); end
      checks++; if (inflight !== 3'(4 - d)) begin errors++; $display("FAIL unstall_inflight d=%0d got=%0d exp=%0d", d, inflight, 4 - d); end
    end
    step();
    buf_rsp_valid = 1'b0;
  endtask

  task automatic test_push_pop();
    req_valid = 2'b10; rsp_ready = 2'b11; buf_rsp_valid = 1'b0;
    step();
    req_valid = 2'b01;
    step();
    req_valid = 2'b10; buf_rsp_valid = 1'b1;
    #1;
    checks++; if (inflight !== 3'd2) begin errors++; $display("FAIL pp_inflight_before got=%0d exp=2", inflight); end
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL pp_req_ready got=%b exp=10", req_ready); end
    checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL pp_rsp_valid0 got=%b exp=10", rsp_valid); end
    step();
    req_valid = 2'b00;
    #1;
    checks++; if (inflight !== 3'd2) begin errors++; $display("FAIL pp_inflight_after got=%0d exp=2", inflight); end
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL pp_rsp_valid1 got=%b exp=01", rsp_valid); end
    step();
    #1;
    checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL pp_rsp_valid2 got=%b exp=10", rsp_valid); end
    step();
    buf_rsp_valid = 1'b0;
    #1;
    checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL pp_drained got=%0d exp=0", inflight); end
  endtask

  task automatic test_orphan();
    buf_rsp_valid = 1'b1; rsp_ready = 2'b11;
    #1;
    checks++; if (buf_rsp_ready !== 1'b0) begin errors++; $display("FAIL orphan_buf_rsp_ready got=%b exp=0", buf_rsp_ready); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL orphan_rsp_valid got=%b exp=00", rsp_valid); end
    checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL orphan_err_early got=%b exp=0", err_orphan); end
    step();
    checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_err_set got=%b exp=1", err_orphan); end
    checks++; if (buf_rsp_ready !== 1'b0) begin errors++; $display("FAIL orphan_held got=%b exp=0", buf_rsp_ready); end
    buf_rsp_valid = 1'b0;
    repeat (10) step();
    checks++; if (err_orphan !== 1'b1) begin errors++; $display("FAIL orphan_err_sticky got=%b exp=1", err_orphan); end
  endtask

  task automatic test_reset_mid();
    req_valid = 2'b01; rsp_ready = 2'b11;
    repeat (3) step();
    req_valid = 2'b00;
    #1;
    checks++; if (inflight !== 3'd3) begin errors++; $display("FAIL rmid_inflight_pre got=%0d exp=3", inflight); end
    rstn = 1'b0; buf_rsp_valid = 1'b1;
    #1;
    checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL rmid_inflight got=%0d exp=0", inflight); end
    checks++; if (err_orphan !== 1'b0) begin errors++; $display("FAIL rmid_err_orphan got=%b exp=0", err_orphan); end
    checks++; if (buf_rsp_ready !== 1'b0) begin errors++; $display("FAIL rmid_buf_rsp_ready got=%b exp=0", buf_rsp_ready); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rmid_rsp_valid got=%b exp=00", rsp_valid); end
    checks++; if (buf_req_valid !== 1'b0) begin errors++; $display("FAIL rmid_buf_req_valid got=%b exp=0", buf_req_valid); end
    step(); step();
    buf_rsp_valid = 1'b0; rstn = 1'b1; req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rmid_first_grant got=%b exp=01", req_ready); end
    checks++; if (buf_req_data !== req_data[0]) begin errors++; $display("FAIL rmid_buf_req_data got=%h exp=%h", buf_req_data, req_data[0]); end
    step();
    req_valid = 2'b00;
    #1;
    checks++; if (inflight !== 3'd1) begin errors++; $display("FAIL rmid_inflight_post got=%0d exp=1", inflight); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_fill_stall();
    test_owner_stall();
    test_push_pop();
    test_orphan();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/modelbuf_read_arbiter.md
# modelbuf_read_arbiter

Shares the single model-buffer read port between NUM_REQ triangle-fetch requesters, such as several scene-reading pipelines rendering in parallel. Requests are arbitrated round-robin onto the buffer's request channel. A tag FIFO records which requester owns each outstanding read. Returned triangles are routed back to their owner in order, with per-requester valid/ready handshakes.

## Interface
- NUM_REQ, 2: number of requesters; legal range is 2..8.
- MAX_OUTSTANDING, 4: tag FIFO depth, i.e. maximum accepted-but-unanswered reads; must be a power of two.
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- req_valid  in  [NUM_REQ]  per-requester read request valid.
- req_ready  out  [NUM_REQ]  per-requester read request accepted.
- req_data  in  [NUM_REQ] x modelbuf_read_t  per-requester {model_index, triangle_index}.
- buf_req_valid  out  1  request to model buffer.
- buf_req_ready  in  1  model buffer accepts request.
- buf_req_data  out  modelbuf_read_t  granted requester's req_data.
- buf_rsp_valid  in  1  triangle returned by model buffer; responses arrive in request order.
- buf_rsp_ready  out  1  response consumed.
- buf_rsp_data  in  triangle_t  returned triangle.
- buf_rsp_metadata  in  triangle_meta_t  returned metadata (last flag).
- rsp_valid  out  [NUM_REQ]  response valid, one-hot to the owning requester.
- rsp_ready  in  [NUM_REQ]  per-requester response ready.
- rsp_data  out  triangle_t  buf_rsp_data broadcast to all requesters.
- rsp_metadata  out  triangle_meta_t  buf_rsp_metadata broadcast to all requesters.
- inflight  out  $clog2(MAX_OUTSTANDING+1)  current tag FIFO occupancy.
- err_orphan  out  1  sticky flag: a response arrived with the tag FIFO empty.

## Operation
- **State:**
  - last_grant: requester index.
  - Tag FIFO: MAX_OUTSTANDING entries of $clog2(NUM_REQ) bits, with read/write pointers and a count.
  - err_orphan register.
- **Arbitration (combinational):**
  - Search starts at last_grant+1 and wraps modulo NUM_REQ.
  - grant is the first index with req_valid set.
  - If no req_valid is set, there is no grant.
- **Request channel:**
  - buf_req_valid = (any req_valid) && (count < MAX_OUTSTANDING).
  - buf_req_data = req_data[grant].
  - req_ready[i] = (i == grant) && buf_req_valid && buf_req_ready.
  - On a request handshake: push grant into the FIFO and set last_grant <= grant.
- **Fairness:** with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0,... with no gaps.
- **Response channel:** head is the FIFO tag at the read pointer.
  - rsp_valid[i] = buf_rsp_valid && (count != 0) && (head == i).
  - buf_rsp_ready = (count != 0) && rsp_ready[head].
  - On a response handshake: pop the FIFO.
- **Back-pressure isolation:** a stalled owner (rsp_ready low) blocks only responses, never the request channel, until the FIFO is full.
- **Simultaneous push and pop:** both occur; count is unchanged; pointers advance independently and wrap at MAX_OUTSTANDING.
- **Full FIFO:** buf_req_valid = 0 and all req_ready = 0, even if a pop happens in the same cycle. A new request may issue the following cycle.
- **Orphan response:** buf_rsp_valid with count == 0:
  - buf_rsp_ready = 0 and all rsp_valid = 0, so the response is held.
  - err_orphan <= 1 and stays set until reset.
- **Pass-through:** metadata passes through unmodified. The arbiter does not interpret the last flag.

## Timing
- **Reset values:**
  - last_grant = NUM_REQ-1, so requester 0 has first priority.
  - FIFO empty, inflight = 0, err_orphan = 0.
  - buf_req_valid = 0, buf_rsp_ready = 0, rsp_valid = 0, req_ready = 0.
- Reset asserted mid-operation discards all outstanding tags. The surrounding design resets the model buffer in the same reset domain.
- **Latency:**
  - Request path: 0 cycles, combinational from req_* to buf_req_*.
  - Response path: 0 cycles, combinational from buf_rsp_* to rsp_*.
  - No combinational path runs from req_* to rsp_*.
- inflight and last_grant update on the clock edge after a handshake.
- buf_req_valid does not depend on buf_req_ready; rsp_valid does not depend on rsp_ready.
- Sustained throughput is 1 request and 1 response per cycle while the FIFO is neither full nor empty.

## Test plan
- **Round-robin rotation:** NUM_REQ=2, both requesters valid for 6 cycles, buf_req_ready=1, responses returned 2 cycles later -> grant sequence 0,1,0,1,0,1, each response routed to the matching rsp_valid bit.
- **Fill and stall:** MAX_OUTSTANDING=4, buf_rsp_valid=0, requester 0 valid -> 4 handshakes, then req_ready=0 and inflight=4. One response pop -> a request issues the next cycle.
- **Owner stall:** requester 1 owns the head tag and holds rsp_ready=0 for 5 cycles -> buf_rsp_ready=0 for 5 cycles, requester 0 keeps issuing until inflight=4, no response is delivered to requester 0.
- **Push/pop same cycle at inflight=2:** -> inflight stays 2, order preserved.
- **Orphan response:** buf_rsp_valid=1 with an empty FIFO -> err_orphan=1 the next cycle, buf_rsp_ready=0, err_orphan still 1 after 10 cycles.
- **Reset mid-operation:** rstn low with inflight=3 -> all outputs at reset values immediately. After release, requester 0 wins the first grant.
